fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of a `fifoController`-based FIFO between `NREQ` producers. It grants at most one word per cycle, never writes while the FIFO reports full, and supports multi-word packets: once a producer starts a packet, it holds the port until it writes a word flagged `last`. The block sits between producer logic (e.g. UART RX, SPI, or timer event sources) and the FIFO write side. It drives the FIFO's `wr` strobe and the write-data register file.

## Interface
- `NREQ`, 4, number of requesters (≥2)
- `DW`, 8, data word width
- `clk` in 1, clock
- `reset` in 1, synchronous, active-high
- `req` in `NREQ`, per-requester word-valid; held with data until granted
- `wdata` in `NREQ*DW`, flattened data; requester i occupies bits [i*DW +: DW]
- `last` in `NREQ`, per-requester end-of-packet flag qualifying the current word
- `fifo_full` in 1, full flag from the FIFO controller
- `gnt` out `NREQ`, one-hot (or zero); word from requester i accepted this cycle
- `fifo_wr` out 1, write strobe to the FIFO controller and storage
- `fifo_wdata` out `DW`, selected write data
- `owner` out `$clog2(NREQ)`, requester currently holding the port (valid when `locked`=1)
- `locked` out 1, a packet is in progress

## Operation
- State machine with two states: IDLE and LOCKED. Registers are `state`, `rr_ptr` (next highest-priority index) and `owner`.
- **IDLE:**
  - If `fifo_full`=0 and `req`≠0, the winner is the first requester with `req` asserted, searching from `rr_ptr` upward and wrapping mod `NREQ`.
  - `gnt[winner]`=1, `fifo_wr`=1, `fifo_wdata`=`wdata[winner]`.
  - If `last[winner]`=1: stay in IDLE; `rr_ptr`←(winner+1) mod `NREQ`.
  - Else: go to LOCKED; `owner`←winner.
- **LOCKED:**
  - Only `owner` is eligible. `gnt[owner]`=`req[owner]` & ~`fifo_full`.
  - On a granted word with `last[owner]`=1: go to IDLE; `rr_ptr`←(owner+1) mod `NREQ`.
  - If the owner deasserts `req`, the lock is retained indefinitely. There is no timeout, and other requesters stall.
- With `fifo_full`=1: `gnt`=0, `fifo_wr`=0, and state and `rr_ptr` are unchanged.
- With no grant, `fifo_wdata`=0.
- `gnt` is at most one-hot. `fifo_wr` = |`gnt`.
- `rr_ptr` wrap: index `NREQ`-1 wraps to 0.
- `last` on an ungranted cycle is ignored.
- `locked`=1 exactly when state=LOCKED. `owner` holds its last value while in IDLE.

## Timing
- `gnt`, `fifo_wr` and `fifo_wdata` are combinational from `req`, `last`, `wdata`, `fifo_full` and state. Grant latency is zero cycles.
- State, `rr_ptr` and `owner` update on the rising edge of `clk` following a grant.
- Single-word packets from a continuously requesting producer can be granted every cycle when no other requester is active.
- Fairness: with all requesters asserting single-word traffic, the grant rotates 0,1,2,3,0,…
- Reset (synchronous, takes priority): state=IDLE, `rr_ptr`=0, `owner`=0.
  - Outputs after reset: `locked`=0, `owner`=0; `gnt`, `fifo_wr` and `fifo_wdata` are 0 unless requests are present.
  - Reset during a packet abandons the lock. The FIFO is not flushed by this block.
- Any grant asserted in the reset cycle is not acted on by the FIFO. The FIFO is reset by the same `reset`.

## Structure
- Package `fifo_arb_pkg`:
  - typedef `arb_state_t` {IDLE, LOCKED}
  - default constants `ARB_NREQ` and `ARB_DW`
  - function `rr_pick(req, ptr)` returning index plus a found flag
- Sub-module `rr_priority_enc`:
  - parameterized `NREQ`
  - inputs `req` and `ptr`
  - outputs `idx` and `valid`
  - purely combinational rotate-then-priority-encode
- Top-level `fifo_wr_arbiter` contains the FSM, registers and data mux.
- The block is instantiated next to `fifoController`, with `fifo_wr`→`wr` and `fifo_full`←`full`.

## Test plan
- **Reset:** after reset with `req`=0000, `gnt`=0, `fifo_wr`=0, `locked`=0, `owner`=0. Then `req`=1111 with all `last`=1 and `wdata` = 0x40..0x43 → `gnt` sequence 0001, 0010, 0100, 1000, 0001 over 5 cycles; `fifo_wdata` 0x40, 0x41, 0x42, 0x43, 0x40.
- **Packet lock:** req1 sends 3 words (0xA0, 0xA1, 0xA2, `last` on the third) while req0 and req2 are held high → `gnt`=0010 for 3 consecutive cycles, `locked`=1 during words 2–3, and `owner`=1. Next grant goes to req2 (`rr_ptr`=2).
- **Full back-pressure:** `fifo_full`=1 for 4 cycles with `req`=0101 → `gnt`=0, `fifo_wr`=0 and state unchanged. When full drops, `gnt`=0001 (`rr_ptr`=0) in the same cycle.
- **Owner stall:** during a locked packet from req3, drop `req[3]` for 3 cycles while `req`=0111 → no grants and `locked` stays 1. Resuming `req[3]` with `last`=1 → grant to 3, then the next grant goes to req0.
- **Reset mid-packet:** req2 has written 1 of 3 words and reset is asserted for 1 cycle → `locked`=0 and `rr_ptr`=0. The next cycle with `req`=0110 grants 0010.
- **End-to-end:** with `fifoController` (AW=2) plus RAM, random `req`/`last` traffic until full → exactly 4 words written, never writing when full, and packet words contiguous in read order.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int ARB_NREQ = 4;
  localparam int ARB_DW   = 8;
  localparam int ARB_PW   = $clog2(ARB_NREQ);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              found;
    logic [ARB_PW-1:0] idx;
  } rr_pick_t;

  // Round-robin pick for the default requester count: first set bit of req
  // at or above ptr, wrapping modulo ARB_NREQ.
  function automatic rr_pick_t rr_pick(input logic [ARB_NREQ-1:0] req,
                                       input logic [ARB_PW-1:0]   ptr);
    rr_pick_t          r;
    logic [ARB_PW-1:0] j;
    r = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = ARB_NREQ - 1; k >= 0; k--) begin
      j = ARB_PW'((int'(ptr) + k) % ARB_NREQ);
      if (req[j]) begin
        r.found = 1'b1;
        r.idx   = j;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_enc.sv
// Rotate-then-priority-encode: returns the first asserted request at or
// above i_ptr, wrapping modulo NREQ. Purely combinational.
module rr_priority_enc
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = ARB_NREQ,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [PW-1:0]     w_off;
  logic [PW:0]       w_sum;

  // Bit k of w_rot is request (i_ptr + k) mod NREQ.
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_ptr +: NREQ];

  // Lowest set offset in the rotated vector, then un-rotate back to an index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PW'(k);
    end
    w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    o_valid = |w_rot;
    o_idx   = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// A multi-word packet locks the port to its producer until its last word.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = ARB_NREQ,
  parameter  int DW   = ARB_DW,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  i_req,
  input  logic [NREQ*DW-1:0] i_wdata,
  input  logic [NREQ-1:0]  i_last,
  input  logic             i_fifo_full,
  output logic [NREQ-1:0]  o_gnt,
  output logic             o_fifo_wr,
  output logic [DW-1:0]    o_fifo_wdata,
  output logic [PW-1:0]    o_owner,
  output logic             o_locked
);

  localparam logic [0:0] ST_IDLE   = IDLE;
  localparam logic [0:0] ST_LOCKED = LOCKED;

  logic [0:0]    r_state;
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] r_owner;

  logic [PW-1:0] w_enc_idx;
  logic          w_enc_valid;
  logic [PW-1:0] w_win_idx;
  logic          w_win_valid;
  logic          w_win_last;
  logic          w_grant;
  logic [PW-1:0] w_next_ptr;

  rr_priority_enc #(.NREQ(NREQ)) u_enc (
    .i_req   (i_req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  // Winner selection: round-robin search when idle, owner only when locked.
  always_comb begin
    w_win_idx   = w_enc_idx;
    w_win_valid = w_enc_valid;
    if (r_state == ST_LOCKED) begin
      w_win_idx   = r_owner;
      w_win_valid = i_req[r_owner];
    end
    w_grant    = w_win_valid & ~i_fifo_full;
    w_win_last = i_last[w_win_idx];
    w_next_ptr = (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);
  end

  // One-hot grant and write-data mux; data is zero when nothing is granted.
  always_comb begin
    o_gnt        = '0;
    o_fifo_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant && (w_win_idx == PW'(i))) begin
        o_gnt[i]     = 1'b1;
        o_fifo_wdata = i_wdata[i*DW +: DW];
      end
    end
  end

  assign o_fifo_wr = |o_gnt;
  assign o_locked  = (r_state == ST_LOCKED);
  assign o_owner   = r_owner;

  // State, round-robin pointer and owner advance only on a granted word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else if (w_grant) begin
      if (w_win_last) begin
        r_state  <= ST_IDLE;
        r_rr_ptr <= w_next_ptr;
      end else if (r_state == ST_IDLE) begin
        r_state <= ST_LOCKED;
        r_owner <= w_win_idx;
      end
    end
  end

endmodule
